// File: rtl/debug_frame_rx.sv
// Receive side of the byte-wide debug port: rebuilds the 12-byte debug frame
// into SSFR/CON_SIG/MAC2/MAC1/QD..QA and publishes it atomically with a strobe.
module debug_frame_rx #(
    parameter int unsigned GAP_MAX = 15
) (
    input  logic        CLKEXT,
    input  logic        RST_GLO,
    input  logic        EN_RX,
    input  logic        CLR_RX,
    input  logic        SHIFT_DEB,
    input  logic [7:0]  D_IN,
    output logic [15:0] SSFR_O,
    output logic [15:0] CON_SIG_O,
    output logic [15:0] MAC2_O,
    output logic [15:0] MAC1_O,
    output logic [7:0]  QD_O,
    output logic [7:0]  QC_O,
    output logic [7:0]  QB_O,
    output logic [7:0]  QA_O,
    output logic        FRAME_VALID,
    output logic        BUSY,
    output logic [3:0]  BYTE_CNT,
    output logic        ERR_TIMEOUT,
    output logic        ERR_OVF
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [7:0] GAP_LAST = 8'(GAP_MAX - 1);
    localparam logic [3:0] LAST_IDX = 4'd11;

    state_t             state_q, state_d;
    logic [3:0]         byte_cnt_q, byte_cnt_d;
    logic [7:0]         gap_q, gap_d;
    logic [10:0][7:0]   shadow_q, shadow_d;
    logic [11:0][7:0]   frame_q, frame_d;
    logic               frame_valid_q, frame_valid_d;
    logic               err_timeout_q, err_timeout_d;
    logic               err_ovf_q, err_ovf_d;
    logic               busy;

    always_ff @(posedge CLKEXT or posedge RST_GLO) begin
        if (RST_GLO) begin
            state_q       <= IDLE;
            byte_cnt_q    <= '0;
            gap_q         <= '0;
            shadow_q      <= '0;
            frame_q       <= '0;
            frame_valid_q <= 1'b0;
            err_timeout_q <= 1'b0;
            err_ovf_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            byte_cnt_q    <= byte_cnt_d;
            gap_q         <= gap_d;
            shadow_q      <= shadow_d;
            frame_q       <= frame_d;
            frame_valid_q <= frame_valid_d;
            err_timeout_q <= err_timeout_d;
            err_ovf_q     <= err_ovf_d;
        end
    end

    // Clear beats everything; a receiver disable inside a frame drops it silently.
    always_comb begin
        state_d       = state_q;
        byte_cnt_d    = byte_cnt_q;
        gap_d         = gap_q;
        shadow_d      = shadow_q;
        frame_d       = frame_q;
        frame_valid_d = 1'b0;
        err_timeout_d = err_timeout_q;
        err_ovf_d     = err_ovf_q;

        if (CLR_RX) begin
            state_d       = IDLE;
            byte_cnt_d    = '0;
            gap_d         = '0;
            shadow_d      = '0;
            frame_d       = '0;
            err_timeout_d = 1'b0;
            err_ovf_d     = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (EN_RX && SHIFT_DEB) begin
                        shadow_d[0] = D_IN;
                        byte_cnt_d  = 4'd1;
                        gap_d       = '0;
                        state_d     = RECV;
                    end
                end
                RECV: begin
                    if (!EN_RX) begin
                        state_d    = IDLE;
                        byte_cnt_d = '0;
                        gap_d      = '0;
                    end else if (SHIFT_DEB) begin
                        gap_d = '0;
                        if (byte_cnt_q == LAST_IDX) begin
                            frame_d       = {D_IN, shadow_q};
                            frame_valid_d = 1'b1;
                            byte_cnt_d    = '0;
                            state_d       = DRAIN;
                        end else begin
                            shadow_d[byte_cnt_q] = D_IN;
                            byte_cnt_d           = byte_cnt_q + 4'd1;
                        end
                    end else if (gap_q == GAP_LAST) begin
                        err_timeout_d = 1'b1;
                        byte_cnt_d    = '0;
                        gap_d         = '0;
                        state_d       = IDLE;
                    end else begin
                        gap_d = gap_q + 8'd1;
                    end
                end
                DRAIN: begin
                    if (!EN_RX) begin
                        state_d    = IDLE;
                        byte_cnt_d = '0;
                    end else if (SHIFT_DEB) begin
                        err_ovf_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d    = IDLE;
                    byte_cnt_d = '0;
                    gap_d      = '0;
                end
            endcase
        end
    end

    always_comb begin
        busy = (state_q == RECV) || (state_q == DRAIN);
    end

    assign SSFR_O      = {frame_q[0], frame_q[1]};
    assign CON_SIG_O   = {frame_q[2], frame_q[3]};
    assign MAC2_O      = {frame_q[4], frame_q[5]};
    assign MAC1_O      = {frame_q[6], frame_q[7]};
    assign QD_O        = frame_q[8];
    assign QC_O        = frame_q[9];
    assign QB_O        = frame_q[10];
    assign QA_O        = frame_q[11];
    assign FRAME_VALID = frame_valid_q;
    assign BUSY        = busy;
    assign BYTE_CNT    = byte_cnt_q;
    assign ERR_TIMEOUT = err_timeout_q;
    assign ERR_OVF     = err_ovf_q;

endmodule

// File: tb/tb_debug_frame_rx.sv
// Scoreboard bench for debug_frame_rx: expected frames are queued as stimulus
// is issued and popped by a monitor whenever FRAME_VALID is seen.
module tb_debug_frame_rx;

    logic        CLKEXT = 1'b0;
    logic        RST_GLO;
    logic        EN_RX;
    logic        CLR_RX;
    logic        SHIFT_DEB;
    logic [7:0]  D_IN;
    logic [15:0] SSFR_O, CON_SIG_O, MAC2_O, MAC1_O;
    logic [7:0]  QD_O, QC_O, QB_O, QA_O;
    logic        FRAME_VALID, BUSY, ERR_TIMEOUT, ERR_OVF;
    logic [3:0]  BYTE_CNT;

    int check_count = 0;
    int error_count = 0;

    logic [95:0] exp_q[$];

    always #5 CLKEXT = ~CLKEXT;

    debug_frame_rx #(.GAP_MAX(4)) dut (
        .CLKEXT(CLKEXT), .RST_GLO(RST_GLO), .EN_RX(EN_RX), .CLR_RX(CLR_RX),
        .SHIFT_DEB(SHIFT_DEB), .D_IN(D_IN),
        .SSFR_O(SSFR_O), .CON_SIG_O(CON_SIG_O), .MAC2_O(MAC2_O), .MAC1_O(MAC1_O),
        .QD_O(QD_O), .QC_O(QC_O), .QB_O(QB_O), .QA_O(QA_O),
        .FRAME_VALID(FRAME_VALID), .BUSY(BUSY), .BYTE_CNT(BYTE_CNT),
        .ERR_TIMEOUT(ERR_TIMEOUT), .ERR_OVF(ERR_OVF)
    );

    function automatic logic [95:0] fields();
        return {SSFR_O, CON_SIG_O, MAC2_O, MAC1_O, QD_O, QC_O, QB_O, QA_O};
    endfunction

    task automatic checkOutput(input string name, input logic [95:0] actual,
                               input logic [95:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic pushExpected(input logic [15:0] ssfr, input logic [15:0] con,
                                input logic [15:0] mac2, input logic [15:0] mac1,
                                input logic [7:0] qd, input logic [7:0] qc,
                                input logic [7:0] qb, input logic [7:0] qa);
        exp_q.push_back({ssfr, con, mac2, mac1, qd, qc, qb, qa});
    endtask

    task automatic applyStimulus(input logic shift, input logic [7:0] data);
        SHIFT_DEB = shift;
        D_IN      = data;
        @(posedge CLKEXT);
        #1;
    endtask

    task automatic sendBytes(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, base + 8'(i));
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00);
    endtask

    // Every FRAME_VALID must match the oldest outstanding expected frame.
    always @(negedge CLKEXT) begin
        if (FRAME_VALID === 1'b1) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_frame_valid", fields(), 96'h0);
                if (fields() == 96'h0) begin
                    error_count++;
                    $display("[TB] FAIL unexpected_frame_valid: got 1, expected 0");
                end
            end else begin
                checkOutput("frame_fields", fields(), exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        RST_GLO = 1'b1; EN_RX = 1'b0; CLR_RX = 1'b0; SHIFT_DEB = 1'b0; D_IN = 8'h00;
        repeat (2) @(posedge CLKEXT);
        #1;
        checkOutput("reset_fields", fields(), 96'h0);
        checkOutput("reset_status", {FRAME_VALID, BUSY, BYTE_CNT, ERR_TIMEOUT, ERR_OVF}, 96'h0);
        RST_GLO = 1'b0;
        EN_RX   = 1'b1;
        idleCycles(1);

        $display("[TB] contiguous frame 0x11..0x1C");
        pushExpected(16'h1112, 16'h1314, 16'h1516, 16'h1718, 8'h19, 8'h1A, 8'h1B, 8'h1C);
        sendBytes(8'h11, 5);
        checkOutput("byte_cnt_mid", BYTE_CNT, 5);
        checkOutput("busy_mid", BUSY, 1);
        sendBytes(8'h16, 7);
        checkOutput("fv_after_12th", FRAME_VALID, 1);
        checkOutput("drain_status", {BUSY, BYTE_CNT, ERR_TIMEOUT, ERR_OVF}, {1'b1, 4'd0, 2'b00});
        idleCycles(1);
        checkOutput("fv_one_cycle", FRAME_VALID, 0);
        checkOutput("idle_busy", BUSY, 0);

        $display("[TB] gap of 3 tolerated, gap of 4 aborts");
        pushExpected(16'h2122, 16'h2324, 16'h2526, 16'h2728, 8'h29, 8'h2A, 8'h2B, 8'h2C);
        sendBytes(8'h21, 6);
        idleCycles(3);
        checkOutput("gap3_still_busy", {BUSY, ERR_TIMEOUT}, {1'b1, 1'b0});
        sendBytes(8'h27, 6);
        idleCycles(1);
        sendBytes(8'h31, 6);
        idleCycles(3);
        checkOutput("gap3_no_timeout", ERR_TIMEOUT, 0);
        idleCycles(1);
        checkOutput("gap4_timeout", {ERR_TIMEOUT, BUSY, BYTE_CNT}, {1'b1, 1'b0, 4'd0});
        checkOutput("timeout_hold", fields(), 96'h2122_2324_2526_2728_292A2B2C);
        idleCycles(2);

        $display("[TB] 14 contiguous bytes overflow");
        pushExpected(16'h4142, 16'h4344, 16'h4546, 16'h4748, 8'h49, 8'h4A, 8'h4B, 8'h4C);
        sendBytes(8'h41, 14);
        checkOutput("ovf_flags", {ERR_OVF, ERR_TIMEOUT, BUSY}, {1'b1, 1'b1, 1'b1});
        idleCycles(1);
        pushExpected(16'h5152, 16'h5354, 16'h5556, 16'h5758, 8'h59, 8'h5A, 8'h5B, 8'h5C);
        sendBytes(8'h51, 12);
        idleCycles(1);
        checkOutput("after_ovf_hold", fields(), 96'h5152_5354_5556_5758_595A5B5C);

        $display("[TB] clear on 12th byte");
        sendBytes(8'hA0, 11);
        CLR_RX = 1'b1;
        applyStimulus(1'b1, 8'hAB);
        CLR_RX = 1'b0;
        checkOutput("clr_fields", fields(), 96'h0);
        checkOutput("clr_status", {FRAME_VALID, BUSY, BYTE_CNT, ERR_TIMEOUT, ERR_OVF}, 96'h0);
        idleCycles(1);

        $display("[TB] receiver disabled mid-frame");
        sendBytes(8'h61, 8);
        EN_RX = 1'b0;
        idleCycles(1);
        checkOutput("en_drop_status", {BUSY, BYTE_CNT, ERR_TIMEOUT, ERR_OVF}, 96'h0);
        checkOutput("en_drop_hold", fields(), 96'h0);
        EN_RX = 1'b1;
        pushExpected(16'h0102, 16'h0304, 16'h0506, 16'h0708, 8'h09, 8'h0A, 8'h0B, 8'h0C);
        sendBytes(8'h01, 12);
        idleCycles(1);

        $display("[TB] receiver disabled with 12th byte");
        sendBytes(8'h91, 11);
        EN_RX = 1'b0;
        applyStimulus(1'b1, 8'h9C);
        checkOutput("en_12th_discard", {BUSY, BYTE_CNT}, 96'h0);
        checkOutput("en_12th_hold", fields(), 96'h0102_0304_0506_0708_090A0B0C);
        EN_RX = 1'b1;
        idleCycles(1);

        $display("[TB] asynchronous reset mid-frame");
        sendBytes(8'h71, 4);
        SHIFT_DEB = 1'b0;
        #2;
        RST_GLO = 1'b1;
        #1;
        checkOutput("async_rst_fields", fields(), 96'h0);
        checkOutput("async_rst_status", {FRAME_VALID, BUSY, BYTE_CNT, ERR_TIMEOUT, ERR_OVF}, 96'h0);
        @(posedge CLKEXT);
        #3;
        RST_GLO = 1'b0;
        @(posedge CLKEXT);
        #1;
        pushExpected(16'h8182, 16'h8384, 16'h8586, 16'h8788, 8'h89, 8'h8A, 8'h8B, 8'h8C);
        sendBytes(8'h81, 12);
        idleCycles(3);

        checkOutput("scoreboard_drained", 96'(exp_q.size()), 96'h0);
        $display("Result: errors=%0d of %0d checks", error_count, check_count);
        $finish;
    end

endmodule
